ct_serializer: RTL

CT_SERIALIZER -- requirements
Module: ct_serializer

---
 rtl/ct_serializer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/ct_serializer.sv
// Ciphertext/tag byte serializer: two-entry block buffer drained MSB-first onto a
// byte stream, followed by the authentication tag once the final block is out.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// STREAM    | draining buffered ciphertext blocks byte by byte
// TAG_WAIT  | final block fully issued, tag not yet captured
// TAG_OUT   | issuing BLK_SIZE/8 tag bytes, out_last on the final one
module ct_serializer #(
  parameter int BLK_SIZE = 128,
  parameter int NB_W     = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BLK_SIZE-1:0] ct_data,
  input  logic [NB_W-1:0]     ct_nbytes,
  input  logic                ct_valid,
  input  logic                ct_last,
  output logic                ct_ready,
  input  logic [BLK_SIZE-1:0] tag,
  input  logic                tag_valid,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_is_tag,
  output logic                out_last,
  output logic                err
);

  typedef enum logic [1:0] {
    ST_STREAM   = 2'd0,
    ST_TAG_WAIT = 2'd1,
    ST_TAG_OUT  = 2'd2
  } state_t;

  localparam logic [NB_W-1:0] NB_MAX = NB_W'(BLK_SIZE / 8);

  state_t state;
  state_t state_nxt;

  logic [BLK_SIZE-1:0] buf_data [2];
  logic [NB_W-1:0]     buf_nb   [2];
  logic                buf_last [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          count;

  logic [NB_W-1:0]     byte_idx;
  logic [BLK_SIZE-1:0] tag_sh;
  logic [NB_W-1:0]     tag_rem;
  logic                tag_captured;
  logic                last_seen;
  logic                rdy_en;

  logic                accept;
  logic                nb_bad;
  logic [NB_W-1:0]     nb_clamped;
  logic                slot_free;
  logic                head_valid;
  logic                head_empty;
  logic                head_done;
  logic [BLK_SIZE-1:0] head_sh;
  logic                load_ct;
  logic                load_tag;
  logic                pop;
  logic                final_hs;

  // rdy_en keeps ct_ready low until the first edge after reset release
  assign ct_ready   = rdy_en && (count != 2'd2) && !last_seen;
  assign accept     = ct_valid && ct_ready;
  assign nb_bad     = ct_nbytes > NB_MAX;
  assign nb_clamped = nb_bad ? NB_MAX : ct_nbytes;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_STREAM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_STREAM: begin
        if (pop && buf_last[rd_ptr]) begin
          state_nxt = tag_captured ? ST_TAG_OUT : ST_TAG_WAIT;
        end
      end
      ST_TAG_WAIT: begin
        if (tag_captured) begin
          state_nxt = ST_TAG_OUT;
        end
      end
      ST_TAG_OUT: begin
        if (final_hs) begin
          state_nxt = ST_STREAM;
        end
      end
      default: state_nxt = ST_STREAM;
    endcase
  end

  // A zero-byte head entry is retired without using the output slot
  always_comb begin
    slot_free  = !out_valid || out_ready;
    head_valid = count != 2'd0;
    head_empty = buf_nb[rd_ptr] == '0;
    head_done  = byte_idx == (buf_nb[rd_ptr] - NB_W'(1));
    head_sh    = buf_data[rd_ptr] << {byte_idx, 3'b000};
    load_ct    = (state == ST_STREAM) && head_valid && !head_empty && slot_free;
    pop        = (state == ST_STREAM) && head_valid && (head_empty || (load_ct && head_done));
    load_tag   = (state == ST_TAG_OUT) && (tag_rem != '0) && slot_free;
    final_hs   = (state == ST_TAG_OUT) && out_valid && out_ready && out_last;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      buf_data[wr_ptr] <= ct_data;
      buf_nb[wr_ptr]   <= nb_clamped;
      buf_last[wr_ptr] <= ct_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en       <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
      byte_idx     <= '0;
      last_seen    <= 1'b0;
      tag_captured <= 1'b0;
      tag_sh       <= '0;
      tag_rem      <= '0;
      err          <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (accept && !pop) begin
        count <= count + 2'd1;
      end else if (!accept && pop) begin
        count <= count - 2'd1;
      end

      if (pop || final_hs) begin
        byte_idx <= '0;
      end else if (load_ct) begin
        byte_idx <= byte_idx + NB_W'(1);
      end

      if (final_hs) begin
        last_seen <= 1'b0;
      end else if (accept && ct_last) begin
        last_seen <= 1'b1;
      end

      if (final_hs) begin
        tag_captured <= 1'b0;
      end else if (tag_valid && last_seen && !tag_captured) begin
        tag_captured <= 1'b1;
        tag_sh       <= tag;
      end else if (load_tag) begin
        tag_sh <= tag_sh << 8;
      end

      if ((state != ST_TAG_OUT) && (state_nxt == ST_TAG_OUT)) begin
        tag_rem <= NB_MAX;
      end else if (load_tag) begin
        tag_rem <= tag_rem - NB_W'(1);
      end

      if (accept && (nb_bad || ((ct_nbytes == '0) && !ct_last))) begin
        err <= 1'b1;
      end
    end
  end

  // Output register: refilled whenever empty or being consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      out_is_tag <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      if (load_ct) begin
        out_valid  <= 1'b1;
        out_data   <= head_sh[BLK_SIZE-1 -: 8];
        out_is_tag <= 1'b0;
        out_last   <= 1'b0;
      end else if (load_tag) begin
        out_valid  <= 1'b1;
        out_data   <= tag_sh[BLK_SIZE-1 -: 8];
        out_is_tag <= 1'b1;
        out_last   <= tag_rem == NB_W'(1);
      end else if (out_ready) begin
        out_valid  <= 1'b0;
        out_is_tag <= 1'b0;
        out_last   <= 1'b0;
      end
    end
  end

endmodule
